redux_mem_dump: RTL and testbench

Hardware memory-dump unit for the Redux-V core. It snoops the core's data-memory write port and keeps a 256-entry "written" bitmap. On a start pulse, normally the core's halt, it scans data memory from address 0 to 255 through a synchronous read port. Every written location is emitted as an (address, data) pair on a valid/ready stream, so end-of-run memory inspection is done in hardware rather than by the bench.

---
 rtl/redux_mem_dump.sv | 144 ++++++++++++++
 tb/tb_redux_mem_dump.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/redux_mem_dump.sv
// redux_mem_dump
// Memory-dump unit for the Redux-V core. Snoops the core's data-memory write
// port and records every written address in a bitmap. On a start pulse,
// typically the core's halt, it walks the address space from 0 to the top
// address. For each location that was written, it reads the location through
// a synchronous read port. It then emits the (address, data) pair on a
// valid/ready stream.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset (clears bitmap too)
//   wr_en, wr_addr      snooped core data-memory write port
//   start               dump request, only honoured while idle
//   mem_rd_en/addr      read strobe and address to the data memory
//   mem_rd_data         read data, valid one cycle after mem_rd_en
//   out_valid/ready     output stream handshake
//   out_addr/out_data   emitted entry
//   busy                high whenever a dump is in progress (incl. done cycle)
//   done                one-cycle pulse when the scan completes
module redux_mem_dump #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam int                DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    WAIT,
    SEND,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DEPTH-1:0]  bitmap_q;
  logic              hit;

  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] data_p1;

  // Registered bitmap: a write landing on ptr in the same cycle it is scanned
  // is not seen by that scan step, only by later dumps.
  assign hit = bitmap_q[ptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bitmap_q <= '0;
    end else if (wr_en) begin
      bitmap_q[wr_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Stage p1: read data returns one cycle after the strobe issued in SCAN.
  // The entry is captured here and held for the whole SEND state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_p1 <= '0;
      data_p1 <= '0;
    end else if (state_q == WAIT) begin
      addr_p1 <= ptr_q;
      data_p1 <= mem_rd_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          ptr_d   = '0;
        end
      end
      SCAN: begin
        if (hit) begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = ptr_q;
          state_d     = WAIT;
        end else if (ptr_q == PTR_MAX) begin
          state_d = DONE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      WAIT: begin
        state_d = SEND;
      end
      SEND: begin
        // The top address is terminal; ptr never wraps back to 0.
        if (out_ready) begin
          if (ptr_q == PTR_MAX) begin
            state_d = DONE;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            state_d = SCAN;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out_valid = (state_q == SEND);
  assign out_addr  = addr_p1;
  assign out_data  = data_p1;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_redux_mem_dump.sv
// Testbench for redux_mem_dump: a table of memory images is dumped and
// compared against a scoreboard. Hand-written sequences cover writes during
// a scan, ignored start pulses, and a reset in the middle of a dump.
module tb_redux_mem_dump;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic       start;
  logic       mem_rd_en;
  logic [7:0] mem_rd_addr;
  logic [7:0] mem_rd_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_addr;
  logic [7:0] out_data;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  redux_mem_dump #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .start(start), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .busy(busy), .done(done)
  );

  // Data memory model with a synchronous read port.
  logic [7:0] mem [256];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } ent_t;
  ent_t sb[$];

  typedef struct packed {
    int             nw;
    logic [2:0][7:0] wa;
    logic [2:0][7:0] wd;
    int             ne;
    logic [2:0][7:0] ea;
    logic [2:0][7:0] ed;
    int             edges;
    logic           stall;
  } vec_t;
  vec_t vt [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    mem[a]  = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Start a dump and service the output stream until done. exp_edges is the
  // number of clock edges from the edge sampling start to the done cycle.
  task automatic run_dump(input int exp_edges, input bit stall, input bit glitch, input bit mid);
    int k0;
    int rel;
    int busy_n    = 0;
    int done_at   = -1;
    int stall_cnt = 0;
    bit holding   = 0;
    bit g_send    = 0;
    logic [7:0] hold_a, hold_d;
    ent_t e;
    @(negedge clk);
    start = 1'b1;
    k0    = cyc;
    for (int i = 0; i < 2000 && done_at < 0; i++) begin
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
      rel   = cyc - (k0 + 1);
      if (glitch && rel == 2) start = 1'b1;
      if (busy) busy_n++;
      if (done) done_at = rel;
      if (mid && rel == 100) begin
        wr_en = 1'b1; wr_addr = 8'd200; mem[200] = 8'h3C;
        sb.push_back('{a: 8'd200, d: 8'h3C});
      end
      if (mid && rel == 101) begin
        wr_en = 1'b1; wr_addr = 8'd50; mem[50] = 8'h4D;
      end
      if (out_valid) begin
        if (holding) begin
          check("stall_addr_stable", out_addr, hold_a);
          check("stall_data_stable", out_data, hold_d);
        end
        if (glitch && !g_send) begin
          start  = 1'b1;
          g_send = 1'b1;
        end
        if (stall && stall_cnt < 10) begin
          out_ready = 1'b0;
          stall_cnt++;
          holding = 1'b1;
          hold_a  = out_addr;
          hold_d  = out_data;
        end else begin
          out_ready = 1'b1;
          stall_cnt = 0;
          holding   = 1'b0;
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_entry: got addr 0x%0h data 0x%0h, expected none", out_addr, out_data);
          end else begin
            e = sb.pop_front();
            check("entry_addr", out_addr, e.a);
            check("entry_data", out_data, e.d);
          end
        end
      end else begin
        out_ready = 1'b1;
        holding   = 1'b0;
      end
    end
    start = 1'b0;
    wr_en = 1'b0;
    check("done_edges", done_at, exp_edges);
    check("busy_cycles", busy_n, exp_edges + 1);
    check("missing_entries", sb.size(), 0);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("idle_after_done", busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; start = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'hA5;

    vt[0] = '{nw: 3, wa: {8'hFF, 8'h03, 8'h07}, wd: {8'hFF, 8'h05, 8'h00},
              ne: 3, ea: {8'hFF, 8'h07, 8'h03}, ed: {8'hFF, 8'h00, 8'h05},
              edges: 262, stall: 1'b0};
    vt[1] = vt[0];
    vt[1].edges = 292;
    vt[1].stall = 1'b1;
    vt[2] = '{nw: 2, wa: {8'h00, 8'h09, 8'h09}, wd: {8'h00, 8'h02, 8'h01},
              ne: 1, ea: {8'h00, 8'h00, 8'h09}, ed: {8'h00, 8'h00, 8'h02},
              edges: 258, stall: 1'b0};
    vt[3] = '{nw: 2, wa: {8'h00, 8'h00, 8'h80}, wd: {8'h00, 8'h11, 8'h22},
              ne: 2, ea: {8'h00, 8'h80, 8'h00}, ed: {8'h00, 8'h22, 8'h11},
              edges: 260, stall: 1'b0};
    vt[4] = '{nw: 0, wa: '0, wd: '0, ne: 0, ea: '0, ed: '0, edges: 256, stall: 1'b0};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_outputs", {mem_rd_en, mem_rd_addr, out_valid, out_addr, out_data, busy, done}, '0);

    for (int v = 0; v < 5; v++) begin
      do_reset();
      for (int w = 0; w < vt[v].nw; w++) wr(vt[v].wa[w], vt[v].wd[w]);
      for (int x = 0; x < vt[v].ne; x++) sb.push_back('{a: vt[v].ea[x], d: vt[v].ed[x]});
      run_dump(vt[v].edges, vt[v].stall, 1'b0, 1'b0);
    end

    // Writes during the scan: 200 (ahead of ptr) is caught, 50 (behind) is not.
    do_reset();
    run_dump(258, 1'b0, 1'b0, 1'b1);
    sb.push_back('{a: 8'd50, d: 8'h4D});
    sb.push_back('{a: 8'd200, d: 8'h3C});
    run_dump(260, 1'b0, 1'b0, 1'b0);

    // start pulsed again during SCAN and during SEND must not disturb the dump.
    do_reset();
    for (int w = 0; w < vt[0].nw; w++) wr(vt[0].wa[w], vt[0].wd[w]);
    for (int x = 0; x < vt[0].ne; x++) sb.push_back('{a: vt[0].ea[x], d: vt[0].ed[x]});
    run_dump(262, 1'b0, 1'b1, 1'b0);

    // Reset while an entry is stalled in SEND.
    do_reset();
    wr(8'd3, 8'h05);
    wr(8'd7, 8'h00);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
    check("pre_reset_valid", out_valid, 1'b1);
    check("pre_reset_addr", out_addr, 8'd3);
    #2 reset = 1'b1;
    #1;
    check("async_reset_valid", out_valid, 1'b0);
    check("async_reset_busy", busy, 1'b0);
    check("async_reset_outs", {mem_rd_en, mem_rd_addr, out_addr, out_data, done}, '0);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    sb.delete();
    run_dump(256, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
